prf_release_queue: RTL and testbench

// Commit-side producer of physical-register releases for the integer free list.

---
 rtl/prf_release_queue.sv | 95 +++++++++
 tb/tb_prf_release_queue.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/prf_release_queue.sv
// Commit-side release queue for the integer free list.
// Packs stale PRFs from commit and drains them oldest first.
module prf_release_queue #(
  parameter int PRF_INDEX_SIZE = 6,
  parameter int COMMIT_WIDTH   = 4,
  parameter int RENAME_WIDTH   = 4,
  parameter int DEPTH          = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  recover,
  input  logic [COMMIT_WIDTH-1:0] commit_valid,
  input  logic [COMMIT_WIDTH-1:0][PRF_INDEX_SIZE-1:0] commit_prf,
  output logic                  commit_ready,
  output logic [RENAME_WIDTH-1:0] prf_replace_valid,
  output logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0] prf_replace,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                  overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(COMMIT_WIDTH+1);
  localparam int NW = $clog2(RENAME_WIDTH+1);

  logic [PRF_INDEX_SIZE-1:0] mem_q [DEPTH];
  logic [PRF_INDEX_SIZE-1:0] mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] acc;
  logic [NW-1:0] n;
  logic [PW-1:0] rd_idx;
  logic [PW-1:0] wr_idx;

  assign count        = count_q;
  assign overflow     = overflow_q;
  assign commit_ready = count_q <= CW'(DEPTH - COMMIT_WIDTH);

  always_comb begin
    n = '0;
    rd_idx = '0;
    prf_replace_valid = '0;
    prf_replace = '0;
    if (!recover) begin
      if (count_q >= CW'(RENAME_WIDTH)) n = NW'(RENAME_WIDTH);
      else n = NW'(count_q);
    end
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      rd_idx = head_q + PW'(i);
      if (NW'(i) < n) begin
        prf_replace_valid[i] = 1'b1;
        prf_replace[i] = mem_q[rd_idx];
      end
    end
  end

  // Zero is the hardwired register and is never returned to the free list.
  always_comb begin
    acc = '0;
    wr_idx = '0;
    mem_d = mem_q;
    if (commit_ready) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (commit_valid[i] && commit_prf[i] != '0) begin
          wr_idx = tail_q + PW'(acc);
          mem_d[wr_idx] = commit_prf[i];
          acc = acc + AW'(1);
        end
      end
    end
    overflow_d = overflow_q | ((|commit_valid) & ~commit_ready);
    head_d  = head_q + PW'(n);
    tail_d  = tail_q + PW'(acc);
    count_d = count_q + CW'(acc) - CW'(n);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_prf_release_queue.sv
// Scoreboard bench for prf_release_queue.
// Accepted PRFs are queued in order and popped as the DUT drains them.
module tb_prf_release_queue;

  logic clock = 1'b0;
  logic reset;
  logic recover;
  logic [3:0] commit_valid;
  logic [3:0][5:0] commit_prf;
  logic commit_ready;
  logic [3:0] prf_replace_valid;
  logic [3:0][5:0] prf_replace;
  logic [4:0] count;
  logic overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];
  logic model_ovf = 1'b0;

  prf_release_queue dut (
    .clock(clock),
    .reset(reset),
    .recover(recover),
    .commit_valid(commit_valid),
    .commit_prf(commit_prf),
    .commit_ready(commit_ready),
    .prf_replace_valid(prf_replace_valid),
    .prf_replace(prf_replace),
    .count(count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    recover = 1'b0;
    commit_valid = '0;
    commit_prf = '0;
    @(posedge clock);
    #1;
    exp_q.delete();
    model_ovf = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(commit_ready), 1);
    check("rst_valid", 32'(prf_replace_valid), 0);
    check("rst_lanes", 32'(prf_replace), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
  endtask

  // One cycle: apply inputs, compare drain against the scoreboard, clock.
  task automatic step(input logic [3:0] cv, input logic [3:0][5:0] p,
                      input logic rec);
    int n;
    int sz;
    logic [3:0] ev;
    logic [5:0] el;
    recover = rec;
    commit_valid = cv;
    commit_prf = p;
    #1;
    sz = exp_q.size();
    check("count", 32'(count), 32'(sz));
    check("ready", 32'(commit_ready), 32'(sz <= 12));
    n = rec ? 0 : (sz < 4 ? sz : 4);
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      ev[i] = (i < n);
      el = (i < n) ? exp_q[i] : 6'd0;
      check($sformatf("lane%0d", i), 32'(prf_replace[i]), 32'(el));
    end
    check("valid", 32'(prf_replace_valid), 32'(ev));
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
    if (sz <= 12) begin
      for (int i = 0; i < 4; i++)
        if (cv[i] && p[i] != 6'd0) exp_q.push_back(p[i]);
    end else if (cv != 4'd0) begin
      model_ovf = 1'b1;
    end
    @(posedge clock);
    #1;
    check("ovf", 32'(overflow), 32'(model_ovf));
  endtask

  function automatic logic [3:0][5:0] pk(input int a, input int b,
                                          input int c, input int d);
    logic [3:0][5:0] r;
    r[0] = 6'(a);
    r[1] = 6'(b);
    r[2] = 6'(c);
    r[3] = 6'(d);
    return r;
  endfunction

  initial begin
    logic [3:0] cv;
    logic [3:0][5:0] p;
    logic rec;
    do_reset();

    step(4'b1011, pk(5, 9, 33, 12), 1'b0);
    check("t1_count", 32'(count), 3);
    step(4'b0000, '0, 1'b0);
    check("t1_drained", 32'(count), 0);
    step(4'b0000, '0, 1'b0);

    step(4'b1111, pk(0, 7, 0, 8), 1'b0);
    step(4'b0000, '0, 1'b0);
    step(4'b0000, '0, 1'b0);

    for (int k = 0; k < 4; k++)
      step(4'b1111, pk(4*k+1, 4*k+2, 4*k+3, 4*k+4), 1'b1);
    check("t3_full", 32'(count), 16);
    for (int k = 0; k < 5; k++) step(4'b0000, '0, 1'b0);

    step(4'b1111, pk(20, 21, 22, 23), 1'b1);
    step(4'b0011, pk(24, 25, 0, 0), 1'b1);
    step(4'b0000, '0, 1'b1);
    check("t4_hold", 32'(count), 6);
    for (int k = 0; k < 3; k++) step(4'b0000, '0, 1'b0);

    for (int k = 0; k < 4; k++)
      step(4'b1111, pk(30+k, 40+k, 50+k, 60), 1'b1);
    step(4'b0001, pk(11, 0, 0, 0), 1'b0);
    check("t5_ovf", 32'(overflow), 1);
    for (int k = 0; k < 5; k++) step(4'b0000, '0, 1'b0);
    check("t5_sticky", 32'(overflow), 1);
    do_reset();

    for (int k = 0; k < 200; k++) begin
      cv = 4'($urandom_range(0, 15));
      if (exp_q.size() > 12) cv = '0;
      for (int i = 0; i < 4; i++) p[i] = 6'($urandom_range(0, 63));
      rec = ($urandom_range(0, 3) == 0);
      step(cv, p, rec);
    end
    for (int k = 0; k < 6; k++) step(4'b0000, '0, 1'b0);
    check("end_empty", 32'(count), 0);
    check("end_ovf", 32'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
